// File: rtl/data_memory_pkg.sv
// Shared types for the data cache: line-controller states, way field enables
// and the tag/index/chip address slicing helper.
package data_memory_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WB_READ,
      ST_WB_SEND,
      ST_FILL_REQ,
      ST_FILL,
      ST_TAG,
      ST_DONE
   } cache_line_state_t;

   // Per-field enables on a way port, ordered {valid, dirty, tag, data}.
   typedef struct packed {
      logic valid;
      logic dirty;
      logic tag;
      logic data;
   } field_enable_t;

   localparam field_enable_t FIELD_DATA = '{valid: 1'b0, dirty: 1'b0, tag: 1'b0, data: 1'b1};
   localparam field_enable_t FIELD_META = '{valid: 1'b1, dirty: 1'b1, tag: 1'b1, data: 1'b0};

   typedef enum logic [1:0] {
      ADDR_TAG,
      ADDR_INDEX,
      ADDR_CHIP
   } addr_field_e;

   // Byte address layout: {tag, index, chip, 2'b00}; the result is right-aligned.
   function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                              input addr_field_e field,
                                              input int unsigned addr_width,
                                              input int unsigned chip_addr);
      logic [31:0] shifted;
      logic [31:0] mask;
      shifted = '0;
      mask    = '0;
      unique case (field)
         ADDR_CHIP: begin
            shifted = addr >> 2;
            mask    = (32'd1 << chip_addr) - 32'd1;
         end
         ADDR_INDEX: begin
            shifted = addr >> (chip_addr + 2);
            mask    = (32'd1 << addr_width) - 32'd1;
         end
         default: begin
            shifted = addr >> (addr_width + chip_addr + 2);
            mask    = '1;
         end
      endcase
      return shifted & mask;
   endfunction

endpackage

// File: rtl/data_cache_line_counter.sv
// Word-in-line counter for the line controller: clear has priority over
// increment, and last_o flags the final word of the line.
module data_cache_line_counter #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             incr_i,
   output logic [WIDTH-1:0] count_o,
   output logic             last_o
);

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;

   always_comb begin
      // NOTE: default assigned first so every path drives count_d and no latch is inferred.
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (incr_i) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign last_o  = &count_q;

endmodule

// File: rtl/data_cache_line_controller.sv
// Line-transfer sequencer for the data cache: optional dirty-victim writeback
// through way port 1, then word-by-word refill and tag update through port 0.
module data_cache_line_controller
   import data_memory_pkg::*;
#(
   parameter  int unsigned WAYS        = 2,
   parameter  int unsigned BLOCK_WORDS = 4,
   parameter  int unsigned ADDR_WIDTH  = 7,
   localparam int unsigned CHIP_ADDR   = $clog2(BLOCK_WORDS),
   localparam int unsigned TAG_SIZE    = 32 - ADDR_WIDTH - CHIP_ADDR - 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  miss_i,
   input  logic [31:0]           miss_address_i,
   input  logic [WAYS-1:0]       victim_way_i,
   input  logic                  victim_dirty_i,
   input  logic [TAG_SIZE-1:0]   victim_tag_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [WAYS-1:0]       enable_way_o,
   output logic [3:0]            port0_enable_o,
   output logic [CHIP_ADDR-1:0]  port0_chip_select_o,
   output logic [ADDR_WIDTH-1:0] port0_address_o,
   output logic                  port0_write_o,
   output logic [3:0]            port0_byte_write_o,
   output logic [31:0]           port0_word_o,
   output logic [TAG_SIZE-1:0]   port0_tag_o,
   output logic                  port0_valid_o,
   output logic                  port0_dirty_o,
   output logic                  port1_read_o,
   output logic [3:0]            port1_enable_o,
   output logic [CHIP_ADDR-1:0]  port1_chip_select_o,
   output logic [ADDR_WIDTH-1:0] port1_address_o,
   input  logic [31:0]           port1_word_i,
   output logic                  mem_write_o,
   output logic                  mem_read_o,
   output logic [31:0]           mem_address_o,
   output logic [31:0]           mem_data_o,
   input  logic                  mem_ready_i,
   input  logic                  mem_valid_i,
   input  logic [31:0]           mem_data_i
);

   cache_line_state_t     state_d, state_q;
   logic [ADDR_WIDTH-1:0] index_d, index_q;
   logic [TAG_SIZE-1:0]   miss_tag_d, miss_tag_q;
   logic [TAG_SIZE-1:0]   victim_tag_d, victim_tag_q;
   logic [WAYS-1:0]       victim_way_d, victim_way_q;
   logic [31:0]           wb_data_d, wb_data_q;
   logic                  wb_held_d, wb_held_q;
   logic                  cnt_clear, cnt_incr, cnt_last;
   logic [CHIP_ADDR-1:0]  count;

   data_cache_line_counter #(.WIDTH(CHIP_ADDR)) u_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (cnt_clear),
      .incr_i  (cnt_incr),
      .count_o (count),
      .last_o  (cnt_last)
   );

   always_comb begin
      state_d             = state_q;
      index_d             = index_q;
      miss_tag_d          = miss_tag_q;
      victim_tag_d        = victim_tag_q;
      victim_way_d        = victim_way_q;
      wb_data_d           = wb_data_q;
      wb_held_d           = wb_held_q;
      cnt_clear           = 1'b0;
      cnt_incr            = 1'b0;
      busy_o              = (state_q != ST_IDLE);
      done_o              = 1'b0;
      enable_way_o        = '0;
      port0_enable_o      = '0;
      port0_chip_select_o = '0;
      port0_address_o     = '0;
      port0_write_o       = 1'b0;
      port0_byte_write_o  = '0;
      port0_word_o        = '0;
      port0_tag_o         = '0;
      port0_valid_o       = 1'b0;
      port0_dirty_o       = 1'b0;
      port1_read_o        = 1'b0;
      port1_enable_o      = '0;
      port1_chip_select_o = '0;
      port1_address_o     = '0;
      mem_write_o         = 1'b0;
      mem_read_o          = 1'b0;
      mem_address_o       = '0;
      mem_data_o          = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (miss_i) begin
               index_d      = ADDR_WIDTH'(addr_field(miss_address_i, ADDR_INDEX, ADDR_WIDTH, CHIP_ADDR));
               miss_tag_d   = TAG_SIZE'(addr_field(miss_address_i, ADDR_TAG, ADDR_WIDTH, CHIP_ADDR));
               victim_tag_d = victim_tag_i;
               victim_way_d = victim_way_i;
               wb_held_d    = 1'b0;
               cnt_clear    = 1'b1;
               state_d      = victim_dirty_i ? ST_WB_READ : ST_FILL_REQ;
            end
         end
         ST_WB_READ: begin
            port1_read_o        = 1'b1;
            port1_enable_o      = FIELD_DATA;
            port1_chip_select_o = count;
            port1_address_o     = index_q;
            state_d             = ST_WB_SEND;
         end
         ST_WB_SEND: begin
            // Way data arrives the cycle after the read strobe; register it before requesting.
            if (!wb_held_q) begin
               wb_data_d = port1_word_i;
               wb_held_d = 1'b1;
            end else begin
               mem_write_o   = 1'b1;
               mem_address_o = {victim_tag_q, index_q, count, 2'b00};
               mem_data_o    = wb_data_q;
               if (mem_ready_i) begin
                  wb_held_d = 1'b0;
                  if (cnt_last) begin
                     cnt_clear = 1'b1;
                     state_d   = ST_FILL_REQ;
                  end else begin
                     cnt_incr = 1'b1;
                     state_d  = ST_WB_READ;
                  end
               end
            end
         end
         ST_FILL_REQ: begin
            mem_read_o    = 1'b1;
            mem_address_o = {miss_tag_q, index_q, {CHIP_ADDR{1'b0}}, 2'b00};
            if (mem_ready_i) begin
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (mem_valid_i) begin
               port0_write_o       = 1'b1;
               enable_way_o        = victim_way_q;
               port0_enable_o      = FIELD_DATA;
               port0_chip_select_o = count;
               port0_address_o     = index_q;
               port0_byte_write_o  = 4'hF;
               port0_word_o        = mem_data_i;
               if (cnt_last) begin
                  cnt_clear = 1'b1;
                  state_d   = ST_TAG;
               end else begin
                  cnt_incr = 1'b1;
               end
            end
         end
         ST_TAG: begin
            // Tag and valid are written only after every word, so an aborted fill never hits.
            port0_write_o      = 1'b1;
            enable_way_o       = victim_way_q;
            port0_enable_o     = FIELD_META;
            port0_address_o    = index_q;
            port0_byte_write_o = 4'hF;
            port0_tag_o        = miss_tag_q;
            port0_valid_o      = 1'b1;
            port0_dirty_o      = 1'b0;
            state_d            = ST_DONE;
         end
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         index_q      <= '0;
         miss_tag_q   <= '0;
         victim_tag_q <= '0;
         victim_way_q <= '0;
         wb_data_q    <= '0;
         wb_held_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         index_q      <= index_d;
         miss_tag_q   <= miss_tag_d;
         victim_tag_q <= victim_tag_d;
         victim_way_q <= victim_way_d;
         wb_data_q    <= wb_data_d;
         wb_held_q    <= wb_held_d;
      end
   end

endmodule

// File: tb/tb_data_cache_line_controller.sv
// Scoreboard bench for data_cache_line_controller: expected port0 writes and
// memory writes are queued as stimulus is driven and popped as the DUT emits them.
module tb_data_cache_line_controller;

   localparam int WAYS        = 2;
   localparam int BLOCK_WORDS = 4;
   localparam int ADDR_WIDTH  = 7;
   localparam int CHIP_ADDR   = 2;
   localparam int TAG_SIZE    = 21;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic                  miss_i;
   logic [31:0]           miss_address_i;
   logic [WAYS-1:0]       victim_way_i;
   logic                  victim_dirty_i;
   logic [TAG_SIZE-1:0]   victim_tag_i;
   logic                  busy_o, done_o;
   logic [WAYS-1:0]       enable_way_o;
   logic [3:0]            port0_enable_o;
   logic [CHIP_ADDR-1:0]  port0_chip_select_o;
   logic [ADDR_WIDTH-1:0] port0_address_o;
   logic                  port0_write_o;
   logic [3:0]            port0_byte_write_o;
   logic [31:0]           port0_word_o;
   logic [TAG_SIZE-1:0]   port0_tag_o;
   logic                  port0_valid_o, port0_dirty_o;
   logic                  port1_read_o;
   logic [3:0]            port1_enable_o;
   logic [CHIP_ADDR-1:0]  port1_chip_select_o;
   logic [ADDR_WIDTH-1:0] port1_address_o;
   logic [31:0]           port1_word_i;
   logic                  mem_write_o, mem_read_o;
   logic [31:0]           mem_address_o, mem_data_o;
   logic                  mem_ready_i, mem_valid_i;
   logic [31:0]           mem_data_i;

   always #5 clk_i = ~clk_i;

   data_cache_line_controller #(
      .WAYS(WAYS), .BLOCK_WORDS(BLOCK_WORDS), .ADDR_WIDTH(ADDR_WIDTH)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .miss_i(miss_i), .miss_address_i(miss_address_i),
      .victim_way_i(victim_way_i), .victim_dirty_i(victim_dirty_i), .victim_tag_i(victim_tag_i),
      .busy_o(busy_o), .done_o(done_o), .enable_way_o(enable_way_o),
      .port0_enable_o(port0_enable_o), .port0_chip_select_o(port0_chip_select_o),
      .port0_address_o(port0_address_o), .port0_write_o(port0_write_o),
      .port0_byte_write_o(port0_byte_write_o), .port0_word_o(port0_word_o),
      .port0_tag_o(port0_tag_o), .port0_valid_o(port0_valid_o), .port0_dirty_o(port0_dirty_o),
      .port1_read_o(port1_read_o), .port1_enable_o(port1_enable_o),
      .port1_chip_select_o(port1_chip_select_o), .port1_address_o(port1_address_o),
      .port1_word_i(port1_word_i), .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
      .mem_address_o(mem_address_o), .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i),
      .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i)
   );

   typedef struct packed {
      logic [WAYS-1:0]       way;
      logic [3:0]            en;
      logic [CHIP_ADDR-1:0]  chip;
      logic [ADDR_WIDTH-1:0] addr;
      logic [3:0]            bw;
      logic [31:0]           word;
      logic [TAG_SIZE-1:0]   tag;
      logic                  valid;
      logic                  dirty;
   } p0_pkt_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } mem_pkt_t;

   p0_pkt_t     p0_q[$];
   mem_pkt_t    mw_q[$];
   logic [31:0] way_data[BLOCK_WORDS];
   int          vectors     = 0;
   int          miscompares = 0;

   function automatic logic any_out();
      return |{busy_o, done_o, enable_way_o, port0_enable_o, port0_chip_select_o, port0_address_o,
               port0_write_o, port0_byte_write_o, port0_word_o, port0_tag_o, port0_valid_o,
               port0_dirty_o, port1_read_o, port1_enable_o, port1_chip_select_o, port1_address_o,
               mem_write_o, mem_read_o, mem_address_o, mem_data_o};
   endfunction

   task automatic idle_inputs();
      miss_i         = 1'b0;
      miss_address_i = '0;
      victim_way_i   = '0;
      victim_dirty_i = 1'b0;
      victim_tag_i   = '0;
      port1_word_i   = '0;
      mem_ready_i    = 1'b0;
      mem_valid_i    = 1'b0;
      mem_data_i     = '0;
   endtask

   // One complete miss: drives requester, way and memory, scoreboards every transfer.
   task automatic run_miss(input string name, input logic [31:0] addr, input logic [WAYS-1:0] vway,
                           input logic dirty, input logic [TAG_SIZE-1:0] vtag, input int ready_lat,
                           input logic [15:0] valid_pat, input logic [31:0] data_base,
                           input int abort_after, input logic alt_miss, input int exp_done);
      int cyc, beats, pidx, req_wait;
      logic filling, prev_read, prev_stall, seen_done, aborted;
      logic [CHIP_ADDR-1:0] prev_chip;
      logic [31:0] prev_addr, prev_data;
      logic [ADDR_WIDTH-1:0] idx;
      logic [TAG_SIZE-1:0] mtag;
      p0_pkt_t exp_p0, obs_p0;
      mem_pkt_t exp_mw;

      idx = addr[10:4];
      mtag = addr[31:11];
      p0_q.delete();
      mw_q.delete();
      for (int i = 0; i < BLOCK_WORDS; i++) way_data[i] = $urandom;
      if (dirty)
         for (int i = 0; i < BLOCK_WORDS; i++)
            mw_q.push_back('{addr: {vtag, idx, CHIP_ADDR'(i), 2'b00}, data: way_data[i]});

      cyc = 0; beats = 0; pidx = 0; req_wait = 0;
      filling = 0; prev_read = 0; prev_stall = 0; seen_done = 0; aborted = 0;
      prev_chip = '0; prev_addr = '0; prev_data = '0;

      @(posedge clk_i); #1;
      miss_i = 1'b1; miss_address_i = addr; victim_way_i = vway;
      victim_dirty_i = dirty; victim_tag_i = vtag;

      while (!seen_done && !aborted && cyc < 300) begin
         if (cyc > 0) begin @(posedge clk_i); #1; end
         if (alt_miss && cyc == 3) begin
            miss_address_i = addr ^ 32'h0003_7FF0;
            victim_tag_i   = ~vtag;
            victim_dirty_i = ~dirty;
            victim_way_i   = ~vway;
         end
         port1_word_i = prev_read ? way_data[prev_chip] : $urandom;
         if (mem_write_o || mem_read_o) mem_ready_i = (req_wait >= ready_lat);
         else mem_ready_i = 1'($urandom_range(0, 1));
         if (filling && beats < BLOCK_WORDS) begin
            mem_valid_i = (pidx < 16) ? valid_pat[pidx] : 1'b1;
            mem_data_i  = data_base + 32'(beats);
            pidx++;
            if (abort_after >= 0 && beats == abort_after) begin
               mem_valid_i = 1'b0;
               rst_i = 1'b1;
            end else if (mem_valid_i) begin
               p0_q.push_back('{way: vway, en: 4'b0001, chip: CHIP_ADDR'(beats), addr: idx, bw: 4'hF,
                                word: data_base + 32'(beats), tag: '0, valid: 1'b0, dirty: 1'b0});
               beats++;
               if (beats == BLOCK_WORDS)
                  p0_q.push_back('{way: vway, en: 4'b1110, chip: '0, addr: idx, bw: 4'hF,
                                   word: '0, tag: mtag, valid: 1'b1, dirty: 1'b0});
            end
         end else begin
            mem_valid_i = filling ? 1'b0 : 1'($urandom_range(0, 1));
            mem_data_i  = $urandom;
         end
         #1;

         vectors++;
         if (busy_o !== (cyc > 0)) begin
            miscompares++;
            $display("FAIL %s busy cyc=%0d: got %b want %b", name, cyc, busy_o, cyc > 0);
         end
         vectors++;
         if ((port0_write_o & port1_read_o) !== 1'b0 || (!port0_write_o && enable_way_o !== '0)) begin
            miscompares++;
            $display("FAIL %s port_exclusive cyc=%0d: p0w=%b p1r=%b way=%b want no overlap, way=0 off-write",
                     name, cyc, port0_write_o, port1_read_o, enable_way_o);
         end
         if (port0_write_o === 1'b1) begin
            vectors++;
            if (p0_q.size() == 0) begin
               miscompares++;
               $display("FAIL %s port0_write cyc=%0d: got write en=%b chip=%0d want none",
                        name, cyc, port0_enable_o, port0_chip_select_o);
            end else begin
               exp_p0 = p0_q.pop_front();
               obs_p0 = '{way: enable_way_o, en: port0_enable_o, chip: port0_chip_select_o,
                          addr: port0_address_o, bw: port0_byte_write_o, word: port0_word_o,
                          tag: port0_tag_o, valid: port0_valid_o, dirty: port0_dirty_o};
               if (exp_p0.en == 4'b0001) begin
                  obs_p0.tag = exp_p0.tag; obs_p0.valid = exp_p0.valid; obs_p0.dirty = exp_p0.dirty;
               end else begin
                  obs_p0.chip = exp_p0.chip; obs_p0.word = exp_p0.word;
               end
               if (obs_p0 !== exp_p0) begin
                  miscompares++;
                  $display("FAIL %s port0_write cyc=%0d: got %h want %h", name, cyc, obs_p0, exp_p0);
               end
            end
         end
         if (port1_read_o === 1'b1) begin
            vectors++;
            if ({port1_enable_o, port1_address_o} !== {4'b0001, idx}) begin
               miscompares++;
               $display("FAIL %s port1_read: got en=%b idx=%h want en=0001 idx=%h",
                        name, port1_enable_o, port1_address_o, idx);
            end
         end
         if (mem_write_o && !mem_ready_i && prev_stall) begin
            vectors++;
            if ({mem_address_o, mem_data_o} !== {prev_addr, prev_data}) begin
               miscompares++;
               $display("FAIL %s wb_hold: got %h/%h want %h/%h", name, mem_address_o, mem_data_o,
                        prev_addr, prev_data);
            end
         end
         if (mem_write_o === 1'b1 && mem_ready_i) begin
            vectors++;
            if (mw_q.size() == 0) begin
               miscompares++;
               $display("FAIL %s mem_write: got addr=%h want none", name, mem_address_o);
            end else begin
               exp_mw = mw_q.pop_front();
               if ({mem_address_o, mem_data_o} !== exp_mw) begin
                  miscompares++;
                  $display("FAIL %s mem_write: got %h/%h want %h/%h", name, mem_address_o,
                           mem_data_o, exp_mw.addr, exp_mw.data);
               end
            end
         end
         if (mem_read_o === 1'b1 && mem_ready_i) begin
            vectors++;
            if (mem_address_o !== {addr[31:4], 4'h0} || mw_q.size() != 0) begin
               miscompares++;
               $display("FAIL %s mem_read: got addr=%h pending_wb=%0d want addr=%h pending_wb=0",
                        name, mem_address_o, mw_q.size(), {addr[31:4], 4'h0});
            end
         end
         if (done_o === 1'b1) begin
            seen_done = 1'b1;
            vectors++;
            if ((exp_done >= 0 && cyc != exp_done) || p0_q.size() != 0 || mw_q.size() != 0) begin
               miscompares++;
               $display("FAIL %s done: got cyc=%0d pending=%0d/%0d want cyc=%0d pending=0/0",
                        name, cyc, p0_q.size(), mw_q.size(), exp_done);
            end
         end

         if (mem_write_o || mem_read_o) req_wait = mem_ready_i ? 0 : req_wait + 1;
         prev_stall = mem_write_o && !mem_ready_i;
         prev_addr  = mem_address_o;
         prev_data  = mem_data_o;
         prev_read  = port1_read_o;
         prev_chip  = port1_chip_select_o;
         if (mem_read_o && mem_ready_i) filling = 1'b1;

         if (rst_i) begin
            @(posedge clk_i); #1;
            mem_valid_i = 1'b1; mem_ready_i = 1'b1; mem_data_i = 32'hDEAD_BEEF; #1;
            vectors++;
            if (any_out() !== 1'b0) begin
               miscompares++;
               $display("FAIL %s reset_abort: got busy=%b p0w=%b want all outputs 0", name, busy_o, port0_write_o);
            end
            @(posedge clk_i); #1;
            rst_i = 1'b0; miss_i = 1'b0; #1;
            vectors++;
            if (any_out() !== 1'b0 || p0_q.size() != 0) begin
               miscompares++;
               $display("FAIL %s reset_release: got busy=%b p0w=%b pending=%0d want 0/0/0",
                        name, busy_o, port0_write_o, p0_q.size());
            end
            aborted = 1'b1;
         end
         cyc++;
      end

      if (!seen_done && !aborted) begin
         miscompares++;
         $display("FAIL %s timeout: done_o not seen within %0d cycles", name, cyc);
      end
      @(posedge clk_i); #1;
      idle_inputs();
      #1;
      vectors++;
      if ({busy_o, done_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL %s after_done: got busy=%b done=%b want 0 0", name, busy_o, done_o);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      idle_inputs();
      miss_i = 1'b1; mem_valid_i = 1'b1; mem_ready_i = 1'b1; victim_dirty_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #2;
         vectors++;
         if (any_out() !== 1'b0) begin
            miscompares++;
            $display("FAIL reset outputs cyc=%0d: got busy=%b mem_r=%b mem_w=%b want all 0",
                     i, busy_o, mem_read_o, mem_write_o);
         end
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      idle_inputs();
   endtask

   task automatic test_clean_miss();
      run_miss("clean_miss", 32'h0000_1230, 2'b01, 1'b0, '0, 0, 16'hFFFF, 32'h0000_00A0, -1, 1'b0, 7);
   endtask

   task automatic test_dirty_miss();
      run_miss("dirty_miss", 32'h0000_4A5C, 2'b10, 1'b1, 21'h5, 0, 16'hFFFF, 32'hC0DE_0000, -1, 1'b0, -1);
   endtask

   task automatic test_ready_stall();
      run_miss("ready_stall", 32'h8765_4320, 2'b10, 1'b1, 21'h1ABCD, 5, 16'hFFFF, 32'h5500_0000, -1, 1'b0, -1);
   endtask

   task automatic test_miss_while_busy();
      run_miss("miss_busy", 32'h0001_2340, 2'b01, 1'b0, 21'h3, 2, 16'hFFFF, 32'h0BAD_0000, -1, 1'b1, 9);
   endtask

   task automatic test_reset_mid_fill();
      run_miss("reset_fill", 32'h0000_0AB0, 2'b10, 1'b0, '0, 0, 16'hFFFF, 32'h7700_0000, 2, 1'b0, -1);
   endtask

   task automatic test_valid_gaps();
      run_miss("valid_gaps", 32'hFFFF_F7F0, 2'b01, 1'b0, '0, 0, 16'h0059, 32'h0000_00A0, -1, 1'b0, 10);
   endtask

   task automatic test_back_to_back();
      run_miss("b2b_dirty", 32'h1357_9BD0, 2'b01, 1'b1, 21'h0F0F0, 1, 16'h00B5, 32'h2468_0000, -1, 1'b0, -1);
      run_miss("b2b_clean", 32'h1357_9BD0, 2'b10, 1'b0, '0, 0, 16'hFFFF, 32'h1111_0000, -1, 1'b0, 7);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clean_miss();
      test_dirty_miss();
      test_ready_stall();
      test_miss_while_busy();
      test_reset_mid_fill();
      test_valid_gaps();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
